// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: transmit-side byte FIFO that drains into a tx_serial UART
// through the sbyte/send/busy handshake.
// Build option: define TX_FIFO_OVF_EN to enable the sticky overflow flag `ovf`.
// When it is undefined, `ovf` is tied low and no overflow logic exists.
module tx_fifo_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk100,
  input  logic                  reset_n,
  input  logic [7:0]            wr_byte,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic [7:0]            sbyte,
  output logic                  send,
  input  logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_level;
  state_t                r_state;
  logic [7:0]            r_sbyte;
  logic                  r_send;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags decode from the registered occupancy, so a byte written into an
  // empty FIFO only becomes poppable on the following cycle.
  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == LVL_ZERO);

  // A write while full is dropped even if a pop happens in the same cycle.
  assign w_push  = wr_en & ~w_full;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty & ~busy;

  assign full    = w_full;
  assign empty   = w_empty;
  assign level   = r_level;
  assign sbyte   = r_sbyte;
  assign send    = r_send;

  // Storage array write; contents are intentionally left unreset.
  always_ff @(posedge clk100) begin
    if (w_push) begin
      r_mem[r_wp] <= wr_byte;
    end
  end

  // Write pointer advances on every accepted byte and wraps modulo depth.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= PTR_ZERO;
    end else if (w_push) begin
      r_wp <= r_wp + PTR_ONE;
    end
  end

  // Occupancy counter: +1 on push, -1 on pop, unchanged when both or neither.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= LVL_ZERO;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Drain FSM: pop into sbyte, pulse send, then track busy high then low.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_send  <= 1'b0;
      r_sbyte <= 8'h00;
      r_rp    <= PTR_ZERO;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_sbyte <= r_mem[r_rp];
            r_rp    <= r_rp + PTR_ONE;
            r_send  <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // tx_serial raises busy one cycle after send; do not re-trigger early.
          if (busy) begin
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TX_FIFO_OVF_EN
  logic r_ovf;

  // Sticky overflow: set by any write attempt while full, cleared only by reset.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (wr_en && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Self-checking bench for tx_fifo_feeder with a behavioural tx_serial busy
// responder and a queue-based reference model of the FIFO.
`timescale 1ns/1ps
module tb_tx_fifo_feeder;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef TX_FIFO_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk100  = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    wr_byte = 8'h00;
  logic          wr_en   = 1'b0;
  logic          full, empty, ovf, send;
  logic [DL:0]   level;
  logic [7:0]    sbyte;
  logic          busy;
  logic          force_busy = 1'b0;
  logic          resp_busy  = 1'b0;

  int errors = 0;
  int checks = 0;

  // responder state
  int         send_count = 0;
  logic [7:0] obs[$];
  bit         pending   = 1'b0;
  bit         prev_send = 1'b0;
  int         busy_cnt  = 0;
  int         busy_min  = 3;
  int         busy_max  = 12;

  assign busy = force_busy | resp_busy;

  tx_fifo_feeder #(.DEPTH_LOG2(DL)) dut (
    .clk100  (clk100),
    .reset_n (reset_n),
    .wr_byte (wr_byte),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf),
    .sbyte   (sbyte),
    .send    (send),
    .busy    (busy)
  );

  always #5 clk100 = ~clk100;

  // Behavioural tx_serial: capture sbyte on send, raise busy the next cycle
  // for a random number of cycles, and check that send is a single-cycle pulse.
  always @(posedge clk100) begin
    #1;
    if (pending) begin
      busy_cnt = $urandom_range(busy_max, busy_min);
      pending  = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (send === 1'b1) begin
      checks++;
      if (prev_send) begin
        errors++;
        $display("FAIL send_width: send high on two consecutive cycles, required one-cycle pulse");
      end
      obs.push_back(sbyte);
      send_count++;
      pending = 1'b1;
    end
    prev_send = (send === 1'b1);
    resp_busy = (busy_cnt > 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input int budget, output bit ok);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk100);
      n++;
      if (empty === 1'b1 && busy === 1'b0) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; force_busy = 1'b0;
    #3;
    checks++;
    if ({full, empty, level, ovf, sbyte, send} !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: full=%b empty=%b level=%0d ovf=%b sbyte=%h send=%b, required 0 1 0 0 00 0",
               full, empty, level, ovf, sbyte, send);
    end
    @(negedge clk100); @(negedge clk100);
    reset_n = 1'b1;
    @(negedge clk100);
  endtask

  task automatic test_busy_after_reset();
    int base;
    int n = 0;
    bit ok;
    obs.delete();
    force_busy = 1'b1;
    reset_n = 1'b0;
    @(negedge clk100);
    reset_n = 1'b1;
    @(negedge clk100);
    wr_en = 1'b1; wr_byte = 8'hA5;
    @(negedge clk100);
    wr_en = 1'b0;
    base = send_count;
    repeat (20) @(negedge clk100);
    checks++;
    if (send_count != base) begin
      errors++;
      $display("FAIL busy_hold_nosend: sends=%0d while busy, required 0", send_count - base);
    end
    checks++;
    if (level !== 5'd1) begin
      errors++;
      $display("FAIL busy_hold_level: level=%0d, required 1", level);
    end
    force_busy = 1'b0;
    while (send_count == base && n < 5) begin
      @(negedge clk100);
      n++;
    end
    checks++;
    if (send_count == base) begin
      errors++;
      $display("FAIL busy_release_send: no send within 5 cycles of busy release, required one");
    end
    checks++;
    if (sbyte !== 8'hA5) begin
      errors++;
      $display("FAIL busy_release_sbyte: sbyte=%h, required a5", sbyte);
    end
    wait_drain(500, ok);
    checks++;
    if (!ok || send_count != base + 1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL busy_release_once: sends=%0d empty=%b, required 1 and 1", send_count - base, empty);
    end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    bit ok;
    b = 8'($urandom_range(255, 1));
    wr_en = 1'b1; wr_byte = b;
    @(negedge clk100);
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd1 || send !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: level=%0d send=%b, required 1 0", level, send);
    end
    @(negedge clk100);
    checks++;
    if (send !== 1'b1 || sbyte !== b) begin
      errors++;
      $display("FAIL latency_n2: send=%b sbyte=%h, required 1 %h", send, sbyte, b);
    end
    wait_drain(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL latency_drain: level=%0d, required drained", level);
    end
  endtask

  task automatic test_burst3();
    logic [7:0] exp[$];
    int base;
    bit ok;
    obs.delete();
    exp = '{8'h41, 8'h42, 8'h43};
    base = send_count;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_byte = exp[i];
      @(negedge clk100);
    end
    wr_en = 1'b0;
    wait_drain(1000, ok);
    checks++;
    if (!ok || send_count - base != 3 || obs.size() != 3) begin
      errors++;
      $display("FAIL burst3_count: sends=%0d captured=%0d, required 3", send_count - base, obs.size());
    end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL burst3_byte%0d: got %h, required %h", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    obs.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_at_full: full=%b level=%0d ovf=%b, required 1 16 0", full, level, ovf);
        end
      end
      wr_en = 1'b1; wr_byte = 8'(i);
      @(negedge clk100);
    end
    wr_en = 1'b0;
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || ovf !== OVF_ON) begin
      errors++;
      $display("FAIL ovf_after_drop: full=%b level=%0d ovf=%b, required 1 16 %b", full, level, ovf, OVF_ON);
    end
    force_busy = 1'b0;
    wait_drain(3000, ok);
    checks++;
    if (!ok || obs.size() != 16) begin
      errors++;
      $display("FAIL ovf_drain_count: captured=%0d, required 16", obs.size());
    end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_drain_byte%0d: got %h, required %h", i, obs[i], 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] data[$];
    int idx = 0;
    int cyc = 0;
    bit ok;
    obs.delete();
    busy_min = 8; busy_max = 12;
    for (int i = 0; i < 40; i++) data.push_back(8'($urandom));
    while (idx < 40 && cyc < 3000) begin
      if (full === 1'b0) begin
        wr_en = 1'b1; wr_byte = data[idx]; idx++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk100);
      cyc++;
    end
    wr_en = 1'b0;
    checks++;
    if (idx < 40) begin
      errors++;
      $display("FAIL wrap_write_timeout: wrote %0d, required 40", idx);
    end
    wait_drain(3000, ok);
    checks++;
    if (!ok || obs.size() != 40 || level !== 5'd0) begin
      errors++;
      $display("FAIL wrap_count: captured=%0d level=%0d, required 40 0", obs.size(), level);
    end
    for (int i = 0; i < 40 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== data[i]) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %h, required %h", i, obs[i], data[i]);
      end
    end
    busy_min = 3; busy_max = 12;
  endtask

  task automatic test_push_pop();
    logic [7:0] exp[$];
    bit ok;
    obs.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_byte = exp[i];
      @(negedge clk100);
    end
    wr_en = 1'b0;
    @(negedge clk100);
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL pushpop_pre: level=%0d, required 5", level);
    end
    force_busy = 1'b0;
    wr_en = 1'b1; wr_byte = exp[5];
    @(negedge clk100);
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd5 || send !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_level: level=%0d send=%b, required 5 1", level, send);
    end
    wait_drain(2000, ok);
    checks++;
    if (!ok || obs.size() != 6) begin
      errors++;
      $display("FAIL pushpop_count: captured=%0d, required 6", obs.size());
    end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL pushpop_byte%0d: got %h, required %h", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_byte = 8'hC1 + 8'(i);
      @(negedge clk100);
    end
    wr_en = 1'b0;
    force_busy = 1'b0;
    @(negedge clk100);
    force_busy = 1'b1;
    checks++;
    if (send !== 1'b1 || level !== 5'd3) begin
      errors++;
      $display("FAIL midrst_send: send=%b level=%0d, required 1 3", send, level);
    end
    repeat (3) @(negedge clk100);
    checks++;
    if (level !== 5'd3 || sbyte !== 8'hC1) begin
      errors++;
      $display("FAIL midrst_waitlo: level=%0d sbyte=%h, required 3 c1", level, sbyte);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({full, empty, level, ovf, sbyte, send} !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midrst_values: full=%b empty=%b level=%0d ovf=%b sbyte=%h send=%b, required 0 1 0 0 00 0",
               full, empty, level, ovf, sbyte, send);
    end
    @(negedge clk100);
    reset_n = 1'b1;
    force_busy = 1'b0;
    base = send_count;
    repeat (40) @(negedge clk100);
    checks++;
    if (send_count != base || empty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_nosend: sends=%0d empty=%b, required 0 1", send_count - base, empty);
    end
  endtask

  task automatic test_random();
    logic [7:0] acc[$];
    int base;
    int ml;
    bit dropped = 1'b0;
    bit ok;
    logic [7:0] b;
    reset_n = 1'b0;
    @(negedge clk100);
    reset_n = 1'b1;
    @(negedge clk100);
    obs.delete();
    busy_min = 1; busy_max = 6;
    base = send_count;
    for (int c = 0; c < 400; c++) begin
      ml = acc.size() - (send_count - base);
      checks++;
      if ({level, full, empty} !== {5'(ml), (ml == DEPTH), (ml == 0)}) begin
        errors++;
        $display("FAIL rand_level_c%0d: level=%0d full=%b empty=%b, required %0d %b %b",
                 c, level, full, empty, ml, (ml == DEPTH), (ml == 0));
      end
      b = 8'($urandom);
      wr_en = ($urandom_range(3, 0) != 0);
      wr_byte = b;
      if (wr_en) begin
        if (ml < DEPTH) acc.push_back(b);
        else dropped = 1'b1;
      end
      @(negedge clk100);
    end
    wr_en = 1'b0;
    wait_drain(3000, ok);
    checks++;
    if (!ok || obs.size() != acc.size()) begin
      errors++;
      $display("FAIL rand_count: captured=%0d, required %0d", obs.size(), acc.size());
    end
    for (int i = 0; i < acc.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== acc[i]) begin
        errors++;
        $display("FAIL rand_byte%0d: got %h, required %h", i, obs[i], acc[i]);
      end
    end
    checks++;
    if (ovf !== (OVF_ON & dropped)) begin
      errors++;
      $display("FAIL rand_ovf: ovf=%b, required %b", ovf, OVF_ON & dropped);
    end
    busy_min = 3; busy_max = 12;
  endtask

  initial begin
    test_reset();
    test_busy_after_reset();
    test_latency();
    test_burst3();
    test_overflow();
    test_wrap();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
